// File: rtl/pcie_irq_gen.sv
// NVMe interrupt request responder: turns MSI / INTx set/clear levels into the
// PCIe core cfg_interrupt handshake. Optional request timeout: PCIE_IRQ_TIMEOUT_EN.
module pcie_irq_gen #(
    parameter int unsigned C_IRQ_TIMEOUT = 4096
) (
    input  logic       pcie_user_clk,
    input  logic       pcie_user_rst_n,
    input  logic       pcie_msi_irq_set,
    input  logic       pcie_legacy_irq_set,
    input  logic [8:0] pcie_irq_vector,
    input  logic       pcie_legacy_irq_clear,
    output logic       pcie_irq_done,
    output logic       cfg_interrupt,
    input  logic       cfg_interrupt_rdy,
    output logic       cfg_interrupt_assert,
    output logic [7:0] cfg_interrupt_di,
    input  logic       cfg_interrupt_msienable,
    input  logic [2:0] cfg_interrupt_mmenable,
    output logic       irq_intx_asserted,
    output logic       irq_timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MSI_REQ,
        S_INTX_ASSERT,
        S_INTX_DEASSERT,
        S_DONE
    } state_t;

    state_t     state, state_nx;
    logic       timeout_hit;
    logic [3:0] vec_idx;
    logic [2:0] mm_eff;
    logic [5:0] alloc;
    logic [7:0] di_enc;

    function automatic logic is_req(input state_t s);
        return (s == S_MSI_REQ) || (s == S_INTX_ASSERT) || (s == S_INTX_DEASSERT);
    endfunction

    // Lowest set bit wins; vectors past the allocation collapse onto the last one.
    always_comb begin
        vec_idx = 4'd0;
        for (int i = 8; i >= 0; i--)
            if (pcie_irq_vector[i]) vec_idx = 4'(i);
        mm_eff = (cfg_interrupt_mmenable > 3'd5) ? 3'd5 : cfg_interrupt_mmenable;
        alloc  = 6'd1 << mm_eff;
        di_enc = ({2'b00, vec_idx} < alloc) ? {4'b0000, vec_idx} : {2'b00, alloc - 6'd1};
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (pcie_msi_irq_set)
                    state_nx = cfg_interrupt_msienable ? S_MSI_REQ : S_DONE;
                else if (pcie_legacy_irq_set)
                    state_nx = irq_intx_asserted ? S_DONE : S_INTX_ASSERT;
                else if (pcie_legacy_irq_clear && irq_intx_asserted)
                    state_nx = S_INTX_DEASSERT;
            end
            S_MSI_REQ, S_INTX_ASSERT:
                if (cfg_interrupt_rdy || timeout_hit) state_nx = S_DONE;
            S_INTX_DEASSERT:
                if (cfg_interrupt_rdy || timeout_hit) state_nx = S_IDLE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            state                <= S_IDLE;
            irq_intx_asserted    <= 1'b0;
            cfg_interrupt        <= 1'b0;
            cfg_interrupt_assert <= 1'b0;
            cfg_interrupt_di     <= 8'd0;
            pcie_irq_done        <= 1'b0;
        end else begin
            state                <= state_nx;
            cfg_interrupt        <= is_req(state_nx);
            cfg_interrupt_assert <= (state_nx == S_INTX_ASSERT);
            pcie_irq_done        <= (state_nx == S_DONE);
            if (state == S_INTX_ASSERT && cfg_interrupt_rdy)
                irq_intx_asserted <= 1'b1;
            else if (state == S_INTX_DEASSERT && cfg_interrupt_rdy)
                irq_intx_asserted <= 1'b0;
            // Vector is latched once on entry and held for the whole request.
            if (state_nx == S_MSI_REQ) begin
                if (state != S_MSI_REQ) cfg_interrupt_di <= di_enc;
            end else begin
                cfg_interrupt_di <= 8'd0;
            end
        end
    end

`ifdef PCIE_IRQ_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Fires on the edge where the count would reach zero, so the request
    // stays up for exactly C_IRQ_TIMEOUT cycles.
    assign timeout_hit = !cfg_interrupt_rdy && (tmo_cnt <= 16'd1);

    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            tmo_cnt         <= 16'd0;
            irq_timeout_err <= 1'b0;
        end else begin
            if (is_req(state_nx) && state_nx != state)
                tmo_cnt <= 16'(C_IRQ_TIMEOUT);
            else if (is_req(state) && !cfg_interrupt_rdy && tmo_cnt != 16'd0)
                tmo_cnt <= tmo_cnt - 16'd1;
            if (is_req(state) && timeout_hit)
                irq_timeout_err <= 1'b1;
        end
    end
`else
    logic unused_timeout_param;

    assign unused_timeout_param = ^C_IRQ_TIMEOUT;
    assign timeout_hit          = 1'b0;
    assign irq_timeout_err      = 1'b0;
`endif

endmodule

// File: tb/tb_pcie_irq_gen.sv
// Directed bench for pcie_irq_gen: MSI encoding/clamping, INTx assert/deassert
// tracking, disabled-MSI drop, priority, async reset and (when built) timeout.
module tb_pcie_irq_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       msi_set, leg_set, leg_clr, rdy, msien;
    logic [8:0] vec;
    logic [2:0] mmen;
    logic       done, cfg_int, cfg_assert, intx, tmo_err;
    logic [7:0] di;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    pcie_irq_gen #(.C_IRQ_TIMEOUT(8)) dut (
        .pcie_user_clk          (clk),
        .pcie_user_rst_n        (rst_n),
        .pcie_msi_irq_set       (msi_set),
        .pcie_legacy_irq_set    (leg_set),
        .pcie_irq_vector        (vec),
        .pcie_legacy_irq_clear  (leg_clr),
        .pcie_irq_done          (done),
        .cfg_interrupt          (cfg_int),
        .cfg_interrupt_rdy      (rdy),
        .cfg_interrupt_assert   (cfg_assert),
        .cfg_interrupt_di       (di),
        .cfg_interrupt_msienable(msien),
        .cfg_interrupt_mmenable (mmen),
        .irq_intx_asserted      (intx),
        .irq_timeout_err        (tmo_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic msi_req(input string tag, input logic [2:0] mm, input logic [8:0] v,
                           input logic [7:0] exp_di);
        mmen = mm; vec = v; msi_set = 1'b1;
        tick();
        chk({tag, "_cfg"}, 32'(cfg_int), 32'd1);
        chk({tag, "_di"},  32'(di), 32'(exp_di));
        rdy = 1'b1;
        tick();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_cfg_off"}, 32'(cfg_int), 32'd0);
        msi_set = 1'b0; rdy = 1'b0;
        tick();
        chk({tag, "_done_off"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; msi_set = 0; leg_set = 0; leg_clr = 0; rdy = 0;
        msien = 1'b1; mmen = 3'd3; vec = 9'h001;
        repeat (2) tick();
        chk("rst_cfg",    32'(cfg_int), 32'd0);
        chk("rst_done",   32'(done), 32'd0);
        chk("rst_assert", 32'(cfg_assert), 32'd0);
        chk("rst_di",     32'(di), 32'd0);
        chk("rst_intx",   32'(intx), 32'd0);
        chk("rst_tmo",    32'(tmo_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // MSI idx 0, rdy arrives on the third request cycle
        msi_set = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("msi0_cfg",  32'(cfg_int), 32'd1);
            chk("msi0_di",   32'(di), 32'd0);
            chk("msi0_asrt", 32'(cfg_assert), 32'd0);
            chk("msi0_nodone", 32'(done), 32'd0);
            if (k == 2) rdy = 1'b1;
        end
        tick();
        chk("msi0_cfg_off", 32'(cfg_int), 32'd0);
        chk("msi0_done",    32'(done), 32'd1);
        msi_set = 1'b0; rdy = 1'b0;
        tick();
        chk("msi0_done_once", 32'(done), 32'd0);

        msi_req("clamp_mm1",  3'd1, 9'h020, 8'd1);
        msi_req("clamp_mm3",  3'd3, 9'h100, 8'd7);
        msi_req("clamp_mm4",  3'd4, 9'h100, 8'd8);
        msi_req("mm0",        3'd0, 9'h002, 8'd0);
        msi_req("zero_vec",   3'd5, 9'h000, 8'd0);
        msi_req("lowbit",     3'd7, 9'h14c, 8'd2);

        // INTx assert with rdy already high
        leg_set = 1'b1; rdy = 1'b1;
        tick();
        chk("intx_cfg",  32'(cfg_int), 32'd1);
        chk("intx_asrt", 32'(cfg_assert), 32'd1);
        chk("intx_di",   32'(di), 32'd0);
        chk("intx_flag_pre", 32'(intx), 32'd0);
        tick();
        chk("intx_cfg_off", 32'(cfg_int), 32'd0);
        chk("intx_done",    32'(done), 32'd1);
        chk("intx_flag",    32'(intx), 32'd1);
        leg_set = 1'b0; rdy = 1'b0;
        tick();
        chk("intx_done_once", 32'(done), 32'd0);

        // Already asserted: completes without a core request
        leg_set = 1'b1;
        tick();
        chk("intx2_cfg",  32'(cfg_int), 32'd0);
        chk("intx2_done", 32'(done), 32'd1);
        leg_set = 1'b0;
        tick();

        // Deassert: one request, no done
        leg_clr = 1'b1; rdy = 1'b1;
        tick();
        chk("deas_cfg",  32'(cfg_int), 32'd1);
        chk("deas_asrt", 32'(cfg_assert), 32'd0);
        chk("deas_flag_pre", 32'(intx), 32'd1);
        tick();
        chk("deas_cfg_off", 32'(cfg_int), 32'd0);
        chk("deas_nodone",  32'(done), 32'd0);
        chk("deas_flag",    32'(intx), 32'd0);
        tick();
        chk("deas_once", 32'(cfg_int), 32'd0);
        leg_clr = 1'b0; rdy = 1'b0;
        tick();

        // MSI disabled: dropped, done only
        msien = 1'b0; msi_set = 1'b1;
        tick();
        chk("msidis_cfg",  32'(cfg_int), 32'd0);
        chk("msidis_done", 32'(done), 32'd1);
        msi_set = 1'b0;
        tick();
        chk("msidis_once", 32'(done), 32'd0);
        msien = 1'b1;

        // MSI wins over simultaneous legacy set
        mmen = 3'd3; vec = 9'h004; msi_set = 1'b1; leg_set = 1'b1;
        tick();
        chk("prio_cfg",  32'(cfg_int), 32'd1);
        chk("prio_asrt", 32'(cfg_assert), 32'd0);
        chk("prio_di",   32'(di), 32'd2);
        rdy = 1'b1;
        tick();
        chk("prio_done", 32'(done), 32'd1);
        msi_set = 1'b0; rdy = 1'b0;
        tick();
        chk("prio_gap", 32'(cfg_int), 32'd0);
        tick();
        chk("prio_intx_cfg",  32'(cfg_int), 32'd1);
        chk("prio_intx_asrt", 32'(cfg_assert), 32'd1);
        rdy = 1'b1;
        tick();
        chk("prio_intx_done", 32'(done), 32'd1);
        chk("prio_intx_flag", 32'(intx), 32'd1);
        leg_set = 1'b0; rdy = 1'b0;
        tick();

        // Legacy set during an in-flight deassert waits for it
        leg_clr = 1'b1;
        tick();
        chk("wait_deas_cfg", 32'(cfg_int), 32'd1);
        leg_set = 1'b1;
        tick();
        chk("wait_deas_asrt", 32'(cfg_assert), 32'd0);
        chk("wait_deas_nodone", 32'(done), 32'd0);
        rdy = 1'b1; leg_clr = 1'b0;
        tick();
        chk("wait_idle_cfg", 32'(cfg_int), 32'd0);
        chk("wait_idle_flag", 32'(intx), 32'd0);
        rdy = 1'b0;
        tick();
        chk("wait_asrt_cfg",  32'(cfg_int), 32'd1);
        chk("wait_asrt_asrt", 32'(cfg_assert), 32'd1);
        rdy = 1'b1;
        tick();
        chk("wait_asrt_flag", 32'(intx), 32'd1);
        leg_set = 1'b0; rdy = 1'b0;
        tick();

        // Asynchronous reset in the middle of an MSI request
        vec = 9'h001; msi_set = 1'b1;
        tick();
        chk("arst_pre_cfg", 32'(cfg_int), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cfg",  32'(cfg_int), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_flag", 32'(intx), 32'd0);
        msi_set = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("arst_idle_cfg",  32'(cfg_int), 32'd0);
        chk("arst_idle_done", 32'(done), 32'd0);

`ifdef PCIE_IRQ_TIMEOUT_EN
        begin
            int hi = 0;
            msi_set = 1'b1;
            tick();
            for (int k = 0; k < 40 && cfg_int; k++) begin
                hi++;
                tick();
            end
            chk("tmo_len",  32'(hi), 32'd8);
            chk("tmo_done", 32'(done), 32'd1);
            chk("tmo_err",  32'(tmo_err), 32'd1);
            msi_set = 1'b0;
            tick();
            msi_req("tmo_after", 3'd3, 9'h008, 8'd3);
            chk("tmo_sticky", 32'(tmo_err), 32'd1);
        end
`else
        chk("no_tmo_err", 32'(tmo_err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
